// File: rtl/bobing_pkg.sv
// Shared constants and types for the Bo Bing dice roller: face encodings, LFSR defaults, FSM states.
package bobing_pkg;

    localparam int LFSR_W = 16;

    localparam logic [LFSR_W-1:0] DEF_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] DEF_TAPS = 16'hB400;

    localparam logic [2:0] FACE_NONE  = 3'd0;
    localparam logic [2:0] FACE_ONE   = 3'd1;
    localparam logic [2:0] FACE_TWO   = 3'd2;
    localparam logic [2:0] FACE_THREE = 3'd3;
    localparam logic [2:0] FACE_FOUR  = 3'd4;
    localparam logic [2:0] FACE_FIVE  = 3'd5;
    localparam logic [2:0] FACE_SIX   = 3'd6;

    localparam int NUM_DICE = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_HOLD = 2'd2
    } roll_state_e;

    // Raw 3-bit draws of 0 and 7 are not faces and get rejected.
    function automatic logic face_ok(input logic [2:0] r);
        return (r >= FACE_ONE) && (r <= FACE_SIX);
    endfunction

endpackage

// File: rtl/bobing_dice_roller_if.sv
// Roll request / seed inputs and held dice outputs between the roller and its consumer.
interface bobing_dice_roller_if #(
    parameter int CNT_W = 8
);
    logic             seed_load;
    logic [15:0]      seed_in;
    logic             roll;
    logic [2:0]       d1;
    logic [2:0]       d2;
    logic [2:0]       d3;
    logic [2:0]       d4;
    logic [2:0]       d5;
    logic [2:0]       d6;
    logic             busy;
    logic             valid;
    logic             done;
    logic [CNT_W-1:0] roll_cnt;

    modport master (
        output seed_load, seed_in, roll,
        input  d1, d2, d3, d4, d5, d6, busy, valid, done, roll_cnt
    );

    modport slave (
        input  seed_load, seed_in, roll,
        output d1, d2, d3, d4, d5, d6, busy, valid, done, roll_cnt
    );
endinterface

// File: rtl/bobing_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every edge, seed_load overrides the step (zero seed -> SEED).
// Latency: new state visible one edge after load; no backpressure, never stalls.
module bobing_lfsr16
    import bobing_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
    parameter logic [LFSR_W-1:0] TAPS = DEF_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? TAPS : '0);
        // An all-zero LFSR would lock up, so a zero seed falls back to SEED.
        if (seed_load) begin
            state_d = (seed_in == '0) ? SEED : seed_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bobing_dice_roller.sv
// Rolls six dice from LFSR draws with rejection of 0/7; >=6 edges from roll acceptance to valid.
// No backpressure: roll is ignored while busy, dice held in HOLD until the next accepted roll.
module bobing_dice_roller
    import bobing_pkg::*;
#(
    parameter logic [15:0] SEED  = DEF_SEED,
    parameter logic [15:0] TAPS  = DEF_TAPS,
    parameter int          CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bobing_dice_roller_if.slave  bus
);

    logic [LFSR_W-1:0] lfsr_state;
    logic              unused_lfsr_hi;
    logic [2:0]        draw;

    roll_state_e           state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [NUM_DICE-1:0][2:0] dice_q, dice_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    bobing_lfsr16 #(
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (bus.seed_load),
        .seed_in   (bus.seed_in),
        .state     (lfsr_state)
    );

    assign draw           = lfsr_state[2:0];
    assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:3];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dice_d  = dice_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (bus.roll) begin
                    state_d = ST_ROLL;
                    idx_d   = 3'd0;
                    dice_d  = '0;
                end
            end
            ST_ROLL: begin
                // A reseed edge draws nothing; the next draw comes from the new seed.
                if (!bus.seed_load && face_ok(draw)) begin
                    for (int i = 0; i < NUM_DICE; i++) begin
                        if (idx_q == 3'(i)) begin
                            dice_d[i] = draw;
                        end
                    end
                    if (idx_q == 3'(NUM_DICE - 1)) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            dice_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dice_q  <= dice_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy     = (state_q == ST_ROLL);
    assign bus.valid    = (state_q == ST_HOLD);
    assign bus.done     = done_q;
    assign bus.roll_cnt = cnt_q;

    // Partially filled dice are never exposed to the scorer.
    assign bus.d1 = bus.valid ? dice_q[0] : FACE_NONE;
    assign bus.d2 = bus.valid ? dice_q[1] : FACE_NONE;
    assign bus.d3 = bus.valid ? dice_q[2] : FACE_NONE;
    assign bus.d4 = bus.valid ? dice_q[3] : FACE_NONE;
    assign bus.d5 = bus.valid ? dice_q[4] : FACE_NONE;
    assign bus.d6 = bus.valid ? dice_q[5] : FACE_NONE;

endmodule

// File: tb/tb_bobing_dice_roller.sv
// Directed bench for bobing_dice_roller: hand-computed deterministic roll, reseed, re-roll, reset and soak.
module tb_bobing_dice_roller;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bobing_dice_roller_if #(.CNT_W(8)) bus ();

    bobing_dice_roller #(
        .SEED  (16'hACE1),
        .TAPS  (16'hB400),
        .CNT_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] dice();
        return {bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6};
    endfunction

    function automatic logic all_faces_ok();
        logic [17:0] d;
        logic        ok;
        d  = dice();
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (d[i*3 +: 3] < 3'd1 || d[i*3 +: 3] > 3'd6) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.seed_load = 1'b0;
        bus.seed_in   = 16'h0;
        bus.roll      = 1'b0;
        rst_n         = 1'b0;
        edge1();
        edge1();
        rst_n = 1'b1;
    endtask

    // Seed, roll one cycle, optionally pulse roll again before edge extra_edge.
    task automatic det_roll(input logic [15:0] seed, input int extra_edge, input string tag);
        int dones;
        bus.seed_load = 1'b1;
        bus.seed_in   = seed;
        edge1();
        bus.seed_load = 1'b0;
        bus.roll      = 1'b1;
        edge1();
        bus.roll = 1'b0;
        chk({tag, "_busy_e1"}, 32'(bus.busy), 32'd1);
        chk({tag, "_dice_e1"}, 32'(dice()), 32'd0);
        dones = 0;
        for (int e = 2; e <= 10; e++) begin
            bus.roll = (e == extra_edge);
            edge1();
            bus.roll = 1'b0;
            if (bus.done) dones++;
            if (e == 9) chk({tag, "_valid_e9"}, 32'(bus.valid), 32'd0);
        end
        chk({tag, "_valid_e10"}, 32'(bus.valid), 32'd1);
        chk({tag, "_done_e10"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_e10"}, 32'(bus.busy), 32'd0);
        chk({tag, "_dice"}, 32'(dice()), 32'({3'd4, 3'd6, 3'd3, 3'd1, 3'd4, 3'd2}));
        edge1();
        if (bus.done) dones++;
        chk({tag, "_done_e11"}, 32'(bus.done), 32'd0);
        chk({tag, "_done_count"}, 32'(dones), 32'd1);
        chk({tag, "_hold_dice"}, 32'(dice()), 32'({3'd4, 3'd6, 3'd3, 3'd1, 3'd4, 3'd2}));
    endtask

    initial begin
        int dones;
        int waited;
        logic got_valid;
        total = 0;
        bad   = 0;
        bus.seed_load = 1'b0;
        bus.seed_in   = 16'h0;
        bus.roll      = 1'b0;
        rst_n         = 1'b0;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cnt", 32'(bus.roll_cnt), 32'd0);
        chk("rst_dice", 32'(dice()), 32'd0);
        do_reset();

        det_roll(16'hACE1, 0, "det");
        chk("det_cnt", 32'(bus.roll_cnt), 32'd1);

        // Re-roll from HOLD.
        bus.roll = 1'b1;
        edge1();
        bus.roll = 1'b0;
        chk("reroll_valid", 32'(bus.valid), 32'd0);
        chk("reroll_busy", 32'(bus.busy), 32'd1);
        chk("reroll_dice", 32'(dice()), 32'd0);
        dones  = 0;
        waited = 0;
        while (!bus.valid && waited < 200) begin
            edge1();
            waited++;
            if (bus.done) dones++;
        end
        chk("reroll_timeout", 32'(bus.valid), 32'd1);
        chk("reroll_range", 32'(all_faces_ok()), 32'd1);
        edge1();
        if (bus.done) dones++;
        chk("reroll_done_count", 32'(dones), 32'd1);
        chk("reroll_cnt", 32'(bus.roll_cnt), 32'd2);

        do_reset();
        det_roll(16'h0000, 0, "zseed");
        chk("zseed_cnt", 32'(bus.roll_cnt), 32'd1);

        do_reset();
        det_roll(16'hACE1, 5, "busyroll");
        chk("busyroll_cnt", 32'(bus.roll_cnt), 32'd1);

        // Asynchronous reset in the middle of a roll.
        bus.roll = 1'b1;
        edge1();
        bus.roll = 1'b0;
        edge1();
        edge1();
        chk("midrst_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_valid", 32'(bus.valid), 32'd0);
        chk("midrst_cnt", 32'(bus.roll_cnt), 32'd0);
        chk("midrst_dice", 32'(dice()), 32'd0);
        do_reset();

        // Soak: 300 rolls from random seeds, counter wraps to 44.
        for (int n = 0; n < 300; n++) begin
            bus.seed_load = 1'b1;
            bus.seed_in   = 16'($urandom);
            edge1();
            bus.seed_load = 1'b0;
            bus.roll      = 1'b1;
            edge1();
            bus.roll  = 1'b0;
            waited    = 0;
            got_valid = bus.valid;
            while (!got_valid && waited < 200) begin
                edge1();
                waited++;
                got_valid = bus.valid;
            end
            if (!got_valid) begin
                chk("soak_timeout", 32'(got_valid), 32'd1);
                break;
            end
            chk("soak_range", 32'(all_faces_ok()), 32'd1);
        end
        chk("soak_cnt", 32'(bus.roll_cnt), 32'd44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
